// File: rtl/qam_symbol_packer.sv
// 16-QAM symbol packer: sync-byte hunt, nibble-pair packing, flywheel lock,
// and a first-word-fall-through output FIFO with a ready/valid byte port.
module qam_symbol_packer #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         FRAME_BYTES = 16,
  parameter int         MAX_MISS    = 3,
  parameter int         FIFO_DEPTH  = 8
) (
  input  logic                          symbol_clock,
  input  logic                          rst,
  input  logic                          en,
  input  logic [3:0]                    sym_in,
  input  logic                          sym_valid,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic                          locked,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_BYTES) + 1;
  localparam int MW = $clog2(MAX_MISS + 1);

  localparam logic [CW-1:0] LAST_BYTE = CW'(FRAME_BYTES - 1);
  localparam logic [MW-1:0] LAST_MISS = MW'(MAX_MISS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    CHECK
  } state_t;

  state_t        state;
  logic [3:0]    hist;
  logic [3:0]    high;
  logic          phase;
  logic [CW-1:0] count;
  logic [MW-1:0] miss;

  logic          accept;
  logic [7:0]    pair;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign accept = en && sym_valid;
  assign pair   = {high, sym_in};
  assign push   = accept && (state == DATA) && phase;

  always_ff @(posedge symbol_clock or negedge rst) begin
    if (!rst) begin
      state  <= HUNT;
      hist   <= '0;
      high   <= '0;
      phase  <= 1'b0;
      count  <= '0;
      miss   <= '0;
      locked <= 1'b0;
    end else if (accept) begin
      unique case (state)
        HUNT: begin
          hist <= sym_in;
          if ({hist, sym_in} == SYNC_BYTE) begin
            state  <= DATA;
            locked <= 1'b1;
            phase  <= 1'b0;
            count  <= '0;
            miss   <= '0;
          end
        end
        DATA: begin
          phase <= ~phase;
          if (!phase) begin
            high <= sym_in;
          end else if (count == LAST_BYTE) begin
            count <= '0;
            state <= CHECK;
          end else begin
            count <= count + 1'b1;
          end
        end
        CHECK: begin
          phase <= ~phase;
          if (!phase) begin
            high <= sym_in;
          end else if (pair == SYNC_BYTE) begin
            miss  <= '0;
            state <= DATA;
          end else if (miss == LAST_MISS) begin
            // Too many bad sync slots in a row: abandon the flywheel.
            miss   <= '0;
            hist   <= '0;
            locked <= 1'b0;
            state  <= HUNT;
          end else begin
            miss  <= miss + 1'b1;
            state <= DATA;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  assign byte_valid = (fifo_level != '0);
  assign full       = (fifo_level == FULL_LVL);
  assign pop        = byte_valid && byte_ready;
  // A pop on the same edge frees the slot, so a full FIFO still takes the push.
  assign wr         = push && (!full || pop);
  assign byte_out   = byte_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge symbol_clock) begin
    if (wr) begin
      mem[wr_ptr] <= pair;
    end
  end

  always_ff @(posedge symbol_clock or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !wr) begin
        overflow <= 1'b1;
      end
      unique case ({wr, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: doc/qam_symbol_packer.md
Name: qam_symbol_packer

Overview:
- Sits directly downstream of the 16-QAM hard-decision demapper datapath.
- Consumes one 4-bit demapped symbol per valid strobe and hunts for a sync byte to establish nibble/frame alignment.
- Packs nibble pairs into payload bytes and buffers them in a small FIFO with a ready/valid output toward the byte sink.

Parameters:
- SYNC_BYTE, 8'hA5, frame sync pattern as {high nibble, low nibble}.
- FRAME_BYTES, 16, payload bytes between consecutive sync bytes.
- MAX_MISS, 3, consecutive sync mismatches that drop lock.
- FIFO_DEPTH, 8, output FIFO entries (power of two).

Ports:
- symbol_clock  input  1  single clock; all logic rising-edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  block enable; when low, sym_valid is ignored and state holds.
- sym_in  input  4  demapped symbol; bit 3 is MSB.
- sym_valid  input  1  sym_in is valid this cycle.
- byte_out  output  8  FIFO head byte.
- byte_valid  output  1  FIFO not empty.
- byte_ready  input  1  sink accepts byte_out when byte_valid && byte_ready.
- locked  output  1  high in DATA and CHECK states.
- overflow  output  1  sticky; set when a payload byte is dropped because the FIFO is full.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, async): state=HUNT, nibble shift register=0, phase=0, byte count=0, miss count=0, FIFO empty. Outputs: byte_out=0, byte_valid=0, locked=0, overflow=0, fifo_level=0.
- A symbol is accepted on a rising edge with en && sym_valid. No other edge advances the block.
- HUNT:
  - On each accepted symbol, hist <= {hist[3:0], sym_in}.
  - When {hist[3:0], sym_in} == SYNC_BYTE, go to DATA with phase=0, byte count=0, miss count=0.
  - The sync byte is never written to the FIFO.
- DATA:
  - phase 0: latch sym_in as the high nibble; phase <= 1.
  - phase 1: form byte {high, sym_in} and push it to the FIFO; phase <= 0; byte count++.
  - After the FRAME_BYTES-th byte, go to CHECK.
- CHECK:
  - Collect two nibbles the same way and do not push them.
  - If the byte == SYNC_BYTE: miss count <= 0.
  - Else: miss count++.
  - If miss count reaches MAX_MISS, go to HUNT, with hist cleared and locked low from the next cycle. Otherwise go to DATA with byte count=0.
  - A missed sync keeps the assumed frame timing (flywheel).
- FIFO:
  - First-word-fall-through: byte_out shows the head.
  - A pushed byte makes byte_valid high on the cycle after the edge that accepted the low nibble (1-cycle latency).
  - Pop on byte_valid && byte_ready.
  - Push and pop on the same edge: both take effect and the level is unchanged.
  - Full with a push and no pop: the byte is discarded and overflow <= 1 (sticky until reset).
  - Full with simultaneous push and pop: the push succeeds.
  - Empty with a pop request: no effect (byte_valid=0).
  - Pointers wrap modulo FIFO_DEPTH; the level saturates at FIFO_DEPTH by construction.
- en=0:
  - Freezes HUNT/DATA/CHECK, phase and counters.
  - The FIFO still drains on byte_ready.
- Reset asserted mid-frame: everything returns to reset values immediately. Buffered bytes are lost.
- byte_out holds its value while byte_valid && !byte_ready.

Test Plan:
- Lock and pack: reset, then nibbles 3,A,5,1,2 → ignored 3; lock after A,5 (locked=1 on the next cycle); nibbles 1,2 → byte_out=8'h12, byte_valid=1 one cycle after nibble 2.
- Full frame: lock, send 16 bytes 8'h00..8'h0F as nibble pairs, then A,5 → 16 bytes read out in order with byte_ready=1; locked stays 1; fifo_level returns to 0; 8'hA5 never appears at byte_out.
- Loss of lock: after lock, send 3 frames whose sync slot is 8'h00 → locked falls after the 3rd bad sync; the following payload is not pushed until a new A,5 is seen.
- Backpressure/overflow: byte_ready=0, push 9 payload bytes → fifo_level=8, overflow=1, 9th byte absent. Then byte_ready=1 → 8 bytes drain in order; overflow stays 1.
- Simultaneous push/pop at full: fifo_level=8, byte_ready=1 on the same edge as a new byte push → level stays 8, no overflow.
- Enable/reset mid-operation: drop en for 5 cycles between the two nibbles of a byte with sym_valid=1 → nibbles ignored, byte completes correctly after en returns. Assert rst mid-frame → all outputs 0 asynchronously; HUNT after release.
